guvm_obi_mem_responder: RTL

- Synthesizable, parametrised memory responder that stands in for the instruction or data memory of the core under verification.
- Replaces the fixed always-grant / always-valid tie-offs with real grant/rvalid handshaking: programmable per-request latency, back-pressure, bounded outstanding requests, byte-enabled writes.
- Provides a write-monitor tap for scoreboards and a preload port for loading programs.
- Instantiate one per bus (instruction, data) between the core and the testbench interface.

---
 rtl/guvm_obi_mem_responder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/guvm_obi_mem_responder.sv
// Behavioural OBI memory stand-in: grant/rvalid handshake, per-request latency, byte-enabled writes.
// Latency: gnt_o combinational; rvalid_o registered, L+1 cycles after the grant edge (L = min(lat_i, MAX_LAT)).
// Backpressure: gnt_o drops while stall_i is high, while rst_i is high, or once DEPTH requests are outstanding.
//
// Ports:
//   clk_i, rst_i               clock (rising edge), asynchronous active-high reset
//   req_i/addr_i/we_i/be_i/    request from the core; addr_i is a byte address,
//   wdata_i                    be_i only matters for writes
//   gnt_o                      request accepted this cycle
//   rvalid_o/rdata_o           in-order response pulse; rdata_o is 0 for write responses
//   stall_i                    testbench back-pressure on gnt_o
//   lat_i                      latency for the request granted this cycle
//   load_we_i/load_addr_i/     full-word preload into the backing store (word index)
//   load_data_i
//   wr_mon_*                   one-cycle tap of every granted write (raw, unmasked data)
//   outstanding_o              granted requests not yet responded to
module guvm_obi_mem_responder #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_LAT   = 15,
  parameter int unsigned MEM_WORDS = 1024,
  localparam int unsigned BE_W     = DATA_W / 8,
  localparam int unsigned LAT_W    = $clog2(MAX_LAT + 1),
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS),
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              stall_i,
  input  logic [LAT_W-1:0]  lat_i,
  input  logic              load_we_i,
  input  logic [IDX_W-1:0]  load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              wr_mon_valid_o,
  output logic [ADDR_W-1:0] wr_mon_addr_o,
  output logic [DATA_W-1:0] wr_mon_data_o,
  output logic [CNT_W-1:0]  outstanding_o
);

  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One pending response. Read data is captured at grant time so later
  // writes cannot disturb it; writes carry zero data.
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic [LAT_W-1:0]  cnt;
  } entry_t;

  // Backing store: deliberately not reset so preloaded programs survive rst_i.
  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  entry_t [DEPTH-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               wr_mon_valid_q, wr_mon_valid_d;
  logic [ADDR_W-1:0]  wr_mon_addr_q, wr_mon_addr_d;
  logic [DATA_W-1:0]  wr_mon_data_q, wr_mon_data_d;

  logic               gnt;
  logic               pop;
  logic               wr_en;
  logic               load_hit;
  logic [IDX_W-1:0]   req_idx;
  logic [DATA_W-1:0]  cur_word;
  logic [DATA_W-1:0] merge_base;
  logic [DATA_W-1:0]  wr_word;
  logic [LAT_W-1:0]   lat_sat;
  entry_t             head;

  // Address bits above the word index are ignored (the store aliases);
  // they are folded here only so every input bit has a reader.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  assign req_idx  = addr_i[OFF_W +: IDX_W];
  assign cur_word = mem_q[req_idx];

  always_comb begin
    // Registered count only: a pop in this cycle does not free a slot for
    // a grant in the same cycle.
    gnt      = req_i & ~stall_i & ~rst_i & (count_q < CNT_W'(DEPTH));
    wr_en    = gnt & we_i;
    lat_sat  = (lat_i > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : lat_i;

    // A preload to the same word supplies the bytes the write leaves alone.
    load_hit   = load_we_i && (load_addr_i == req_idx);
    merge_base = load_hit ? load_data_i : cur_word;
    wr_word    = merge_base;
    for (int unsigned k = 0; k < BE_W; k++) begin
      if (be_i[k]) begin
        wr_word[8*k +: 8] = wdata_i[8*k +: 8];
      end
    end
  end

  // Write after the preload so enabled bytes of a granted write win when both
  // target the same word; wr_word already carries the preload's other bytes.
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
    if (wr_en) begin
      mem_q[req_idx] <= wr_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-response queue
  // ---------------------------------------------------------------------------
  always_comb begin
    head     = fifo_q[rd_ptr_q];
    pop      = (count_q != '0) && (head.cnt == '0);

    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    // Every counter runs down independently, so a younger entry may reach
    // zero early and simply wait behind the head. Free slots also count
    // down harmlessly; a push overwrites them.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_q[i].cnt != '0) begin
        fifo_d[i].cnt = fifo_q[i].cnt - 1'b1;
      end
    end

    if (gnt) begin
      fifo_d[wr_ptr_q].we    = we_i;
      fifo_d[wr_ptr_q].rdata = we_i ? '0 : cur_word;
      fifo_d[wr_ptr_q].cnt   = lat_sat;
      wr_ptr_d               = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({gnt, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rvalid_d       = pop;
    rdata_d        = pop ? head.rdata : rdata_q;
    wr_mon_valid_d = wr_en;
    wr_mon_addr_d  = wr_en ? addr_i  : wr_mon_addr_q;
    wr_mon_data_d  = wr_en ? wdata_i : wr_mon_data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_q         <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      wr_mon_valid_q <= 1'b0;
      wr_mon_addr_q  <= '0;
      wr_mon_data_q  <= '0;
    end else begin
      fifo_q         <= fifo_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      rvalid_q       <= rvalid_d;
      rdata_q        <= rdata_d;
      wr_mon_valid_q <= wr_mon_valid_d;
      wr_mon_addr_q  <= wr_mon_addr_d;
      wr_mon_data_q  <= wr_mon_data_d;
    end
  end

  assign gnt_o          = gnt;
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign wr_mon_valid_o = wr_mon_valid_q;
  assign wr_mon_addr_o  = wr_mon_addr_q;
  assign wr_mon_data_o  = wr_mon_data_q;
  assign outstanding_o  = count_q;

  // Occupancy can never exceed the queue size, and stall must always block grant.
  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= CNT_W'(DEPTH));
  a_stall_blocks: assert property (@(posedge clk_i) disable iff (rst_i) stall_i |-> !gnt_o);

endmodule
